stage_if_pc: RTL and testbench
==============================

Name: stage_if_pc

Overview:
- Parametrised instruction-fetch PC unit; successor of the fixed +4 fetch stage.
- Drives the instruction-memory request (imaddr/imce) with a ready handshake.
- Supports pipeline stall, branch/jump redirect, exception redirect with priority, and a pending-redirect latch for redirects that arrive while the request is blocked.
- Flags misaligned fetch targets. Hands the PC of each accepted fetch to ID.

Parameters:
ADDR_W, 32, width of PC and imaddr
PC_INIT, 32'hBFC0_0000, reset/boot fetch address (ADDR_W bits)
INSTR_BYTES, 4, PC increment and alignment granule; power of two, at least 1
ALIGN_W, $clog2(INSTR_BYTES), derived; low address bits that must be zero

Ports:
cpu_clk_50M  in  1  clock
cpu_rst  in  1  synchronous reset, active-high
imaddr  out  ADDR_W  instruction-memory address
imce  out  1  instruction-memory request; fetch is accepted when imce && im_ready
im_ready  in  1  instruction memory accepts the request this cycle
stall_i  in  1  hold fetch; ID is not accepting
br_taken_i  in  1  branch/jump redirect request (single-cycle pulse)
br_target_i  in  ADDR_W  branch/jump target
exc_req_i  in  1  exception/eret redirect (single-cycle pulse); also flushes
exc_target_i  in  ADDR_W  exception/eret target
pc_o  out  ADDR_W  PC of the last accepted fetch (instruction data returns the next cycle)
pc_valid_o  out  1  pc_o is valid for ID
adel_o  out  1  fetch-address-error flag; pc_o holds the bad address

Behaviour:
- Reset (cpu_rst=1 at clock edge):
  - imaddr=PC_INIT; imce=0; pc_o=0; pc_valid_o=0; adel_o=0.
  - Pending redirect cleared; state=BOOT.
  - Reset mid-operation discards any pending redirect or blocked fetch.
- States:
  - BOOT: one cycle. Next state=FETCH; imce=1; imaddr stays PC_INIT. The first fetch is PC_INIT, never PC_INIT+INSTR_BYTES.
  - FETCH: normal operation; imce=!stall_i.
  - ERR: entered on a misaligned target. imce=0; adel_o=1. Left only via exc_req_i, which loads exc_target_i and goes to FETCH (or stays in ERR if that target is also misaligned).
- Accept (imce && im_ready, FETCH):
  - imaddr<=next_pc; pc_o<=imaddr; pc_valid_o<=1.
  - Pending redirect is cleared once consumed.
- Blocked (stall_i=1, or imce && !im_ready):
  - imaddr, pc_o and pc_valid_o hold.
  - When stall_i=1, imce=0 in that same cycle (combinational from stall_i, gated by state).
- next_pc priority:
  1. exc_req_i → exc_target_i
  2. pending redirect → pending target
  3. br_taken_i → br_target_i
  4. otherwise imaddr+INSTR_BYTES, modulo 2^ADDR_W; wraps silently, no flag.
- exc_req_i, any cycle, any state (except reset): imaddr<=exc_target_i immediately even if blocked; pc_valid_o<=0 (flush in-flight); pending redirect cleared.
- br_taken_i while blocked: target latched as pending. A newer branch overwrites an older pending branch.
- br_taken_i in the same cycle as exc_req_i: the branch is ignored.
- Pending redirect while blocked: imaddr is NOT changed until the next accept. The accepting cycle issues the old imaddr, then imaddr<=pending target.
- Misalignment: if the selected redirect target has nonzero bits [ALIGN_W-1:0] (and ALIGN_W>0):
  - imaddr<=target; pc_o<=target; pc_valid_o<=1; adel_o<=1; state=ERR.
  - The increment path never produces a misaligned address.
- pc_valid_o drops to 0 only on reset or exc_req_i. While stalled it holds its value.

Test Plan:
- Reset 3 cycles, release → cycle 1 imce=0 (BOOT), imaddr=BFC0_0000; then accepts with im_ready=1 give pc_o=BFC0_0000, BFC0_0004, BFC0_0008 on consecutive cycles.
- im_ready=0 for 3 cycles at imaddr=BFC0_0010 → imaddr holds, imce stays 1, pc_o unchanged; after ready, next pc_o=BFC0_0010.
- stall_i=1 with br_taken_i pulse (target 8000_0100) at imaddr=BFC0_0020 → imce=0, imaddr holds BFC0_0020; on release one accept of BFC0_0020, then imaddr=8000_0100.
- br_taken_i (8000_0200) and exc_req_i (BFC0_0380) in the same cycle → imaddr=BFC0_0380, pc_valid_o=0 next cycle, branch discarded.
- br_target_i=8000_0102 → adel_o=1, pc_o=8000_0102, imce=0 until exc_req_i to BFC0_0380; then FETCH at BFC0_0380, adel_o=0.
- ADDR_W=16, PC_INIT=16'hFFF8 → fetches FFF8, FFFC, 0000 (wrap, no flag); cpu_rst mid-stream → imaddr=FFF8, pending cleared.

Source files
------------

// File: rtl/stage_if_pc.sv
// ============================================================================
// stage_if_pc : instruction-fetch PC unit with stall, branch/exception redirect
// Revision 1.0 : parametrised successor of the fixed +4 fetch stage
// ============================================================================
`default_nettype none

module stage_if_pc #(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] PC_INIT     = 32'hBFC0_0000,
  parameter int                INSTR_BYTES = 4
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst,
  output logic [ADDR_W-1:0] imaddr,
  output logic              imce,
  input  logic              im_ready,
  input  logic              stall_i,
  input  logic              br_taken_i,
  input  logic [ADDR_W-1:0] br_target_i,
  input  logic              exc_req_i,
  input  logic [ADDR_W-1:0] exc_target_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              pc_valid_o,
  output logic              adel_o
);

  localparam int ALIGN_W = $clog2(INSTR_BYTES);
  localparam logic [ADDR_W-1:0] C_INC = ADDR_W'(INSTR_BYTES);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ERR   = 2'd2
  } state_t;

  state_t            r_state,  w_state_n;
  logic [ADDR_W-1:0] r_imaddr, w_imaddr_n;
  logic [ADDR_W-1:0] r_pc,     w_pc_n;
  logic              r_pc_valid, w_pc_valid_n;
  logic              r_adel,   w_adel_n;
  logic              r_pend_v, w_pend_v_n;
  logic [ADDR_W-1:0] r_pend_t, w_pend_t_n;

  logic              w_imce;
  logic              w_accept;
  logic              w_redir;
  logic [ADDR_W-1:0] w_redir_tgt;
  logic              w_exc_mis;
  logic              w_redir_mis;

  // An older pending branch outranks a branch arriving on the accepting cycle.
  assign w_redir     = r_pend_v | br_taken_i;
  assign w_redir_tgt = r_pend_v ? r_pend_t : br_target_i;

  generate
    if (ALIGN_W > 0) begin : g_align_chk
      assign w_exc_mis   = |exc_target_i[ALIGN_W-1:0];
      assign w_redir_mis = |w_redir_tgt[ALIGN_W-1:0];
    end else begin : g_no_align_chk
      assign w_exc_mis   = 1'b0;
      assign w_redir_mis = 1'b0;
    end
  endgenerate

  assign w_imce   = (r_state == ST_FETCH) && !stall_i;
  assign w_accept = w_imce && im_ready;

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      r_state    <= ST_BOOT;
      r_imaddr   <= PC_INIT;
      r_pc       <= '0;
      r_pc_valid <= 1'b0;
      r_adel     <= 1'b0;
      r_pend_v   <= 1'b0;
      r_pend_t   <= '0;
    end else begin
      r_state    <= w_state_n;
      r_imaddr   <= w_imaddr_n;
      r_pc       <= w_pc_n;
      r_pc_valid <= w_pc_valid_n;
      r_adel     <= w_adel_n;
      r_pend_v   <= w_pend_v_n;
      r_pend_t   <= w_pend_t_n;
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_imaddr_n   = r_imaddr;
    w_pc_n       = r_pc;
    w_pc_valid_n = r_pc_valid;
    w_adel_n     = r_adel;
    w_pend_v_n   = r_pend_v;
    w_pend_t_n   = r_pend_t;

    if (exc_req_i) begin
      // Exceptions redirect immediately, even while the request is blocked.
      w_pend_v_n = 1'b0;
      w_imaddr_n = exc_target_i;
      if (w_exc_mis) begin
        w_pc_n       = exc_target_i;
        w_pc_valid_n = 1'b1;
        w_adel_n     = 1'b1;
        w_state_n    = ST_ERR;
      end else begin
        w_pc_valid_n = 1'b0;
        w_adel_n     = 1'b0;
        w_state_n    = ST_FETCH;
      end
    end else begin
      case (r_state)
        ST_BOOT: begin
          w_state_n = ST_FETCH;
          if (br_taken_i) begin
            w_pend_v_n = 1'b1;
            w_pend_t_n = br_target_i;
          end
        end
        ST_FETCH: begin
          if (w_accept) begin
            w_pend_v_n = 1'b0;
            if (w_redir && w_redir_mis) begin
              w_imaddr_n   = w_redir_tgt;
              w_pc_n       = w_redir_tgt;
              w_pc_valid_n = 1'b1;
              w_adel_n     = 1'b1;
              w_state_n    = ST_ERR;
            end else begin
              w_pc_n       = r_imaddr;
              w_pc_valid_n = 1'b1;
              w_imaddr_n   = w_redir ? w_redir_tgt : (r_imaddr + C_INC);
            end
          end else if (br_taken_i) begin
            // Blocked: remember the newest branch, issue it after the next accept.
            w_pend_v_n = 1'b1;
            w_pend_t_n = br_target_i;
          end
        end
        ST_ERR: begin
          w_state_n = ST_ERR;
        end
        default: begin
          w_state_n = ST_ERR;
        end
      endcase
    end
  end

  assign imaddr     = r_imaddr;
  assign imce       = w_imce;
  assign pc_o       = r_pc;
  assign pc_valid_o = r_pc_valid;
  assign adel_o     = r_adel;

endmodule

`default_nettype wire

// File: tb/tb_stage_if_pc.sv
// ============================================================================
// tb_stage_if_pc : directed + randomized bench against a behavioural PC model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_stage_if_pc;

  logic        cpu_clk_50M;
  logic        cpu_rst;
  logic [31:0] imaddr;
  logic        imce;
  logic        im_ready;
  logic        stall_i;
  logic        br_taken_i;
  logic [31:0] br_target_i;
  logic        exc_req_i;
  logic [31:0] exc_target_i;
  logic [31:0] pc_o;
  logic        pc_valid_o;
  logic        adel_o;

  logic        rst16;
  logic [15:0] imaddr16;
  logic        imce16;
  logic        rdy16;
  logic        stl16;
  logic        br16;
  logic [15:0] bt16;
  logic        ex16;
  logic [15:0] et16;
  logic [15:0] pc16;
  logic        pcv16;
  logic        adel16;

  int n_tests = 0;
  int n_fail  = 0;

  stage_if_pc dut (
    .cpu_clk_50M (cpu_clk_50M),
    .cpu_rst     (cpu_rst),
    .imaddr      (imaddr),
    .imce        (imce),
    .im_ready    (im_ready),
    .stall_i     (stall_i),
    .br_taken_i  (br_taken_i),
    .br_target_i (br_target_i),
    .exc_req_i   (exc_req_i),
    .exc_target_i(exc_target_i),
    .pc_o        (pc_o),
    .pc_valid_o  (pc_valid_o),
    .adel_o      (adel_o)
  );

  stage_if_pc #(
    .ADDR_W     (16),
    .PC_INIT    (16'hFFF8),
    .INSTR_BYTES(4)
  ) dut16 (
    .cpu_clk_50M (cpu_clk_50M),
    .cpu_rst     (rst16),
    .imaddr      (imaddr16),
    .imce        (imce16),
    .im_ready    (rdy16),
    .stall_i     (stl16),
    .br_taken_i  (br16),
    .br_target_i (bt16),
    .exc_req_i   (ex16),
    .exc_target_i(et16),
    .pc_o        (pc16),
    .pc_valid_o  (pcv16),
    .adel_o      (adel16)
  );

  initial cpu_clk_50M = 1'b0;
  always #5 cpu_clk_50M = ~cpu_clk_50M;

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Behavioural model: mode -1 unknown, 0 boot, 1 fetching, 2 address error.
  int          m_mode = -1;
  logic [31:0] m_addr, m_pc;
  logic        m_valid, m_adel;
  logic [31:0] m_pend[$];

  function automatic bit misal(input logic [31:0] a);
    return (a & 32'h3) != 0;
  endfunction

  task automatic step(input bit rst, input bit stl, input bit rdy, input bit br,
                      input logic [31:0] bt, input bit ex, input logic [31:0] et);
    bit          acc;
    bit          redir;
    logic [31:0] tgt;
    cpu_rst = rst; stall_i = stl; im_ready = rdy;
    br_taken_i = br; br_target_i = bt; exc_req_i = ex; exc_target_i = et;
    #1;
    if (m_mode >= 0) check("imce", imce, (m_mode == 1) && !stl);
    acc = (m_mode == 1) && !stl && rdy;
    if (rst) begin
      m_addr = 32'hBFC0_0000; m_pc = 0; m_valid = 0; m_adel = 0;
      m_pend.delete(); m_mode = 0;
    end else if (ex) begin
      m_pend.delete();
      m_addr = et;
      if (misal(et)) begin
        m_pc = et; m_valid = 1; m_adel = 1; m_mode = 2;
      end else begin
        m_valid = 0; m_adel = 0; m_mode = 1;
      end
    end else if (m_mode == 2) begin
      m_mode = 2;
    end else if (acc) begin
      redir = (m_pend.size() > 0) || br;
      tgt   = (m_pend.size() > 0) ? m_pend[0] : bt;
      m_pend.delete();
      if (redir && misal(tgt)) begin
        m_addr = tgt; m_pc = tgt; m_valid = 1; m_adel = 1; m_mode = 2;
      end else begin
        m_pc = m_addr; m_valid = 1;
        m_addr = redir ? tgt : m_addr + 32'd4;
      end
    end else begin
      if (br) begin
        m_pend.delete();
        m_pend.push_back(bt);
      end
      if (m_mode == 0) m_mode = 1;
    end
    @(posedge cpu_clk_50M);
    #1;
    check("imaddr", imaddr, m_addr);
    check("pc_o", pc_o, m_pc);
    check("pc_valid", pc_valid_o, m_valid);
    check("adel", adel_o, m_adel);
  endtask

  initial begin
    logic [31:0] bt, et;
    rst16 = 1'b1; rdy16 = 1'b0; stl16 = 1'b0; br16 = 1'b0; bt16 = '0; ex16 = 1'b0; et16 = '0;

    repeat (3) step(1, 0, 0, 0, 0, 0, 0);
    check("rst_imaddr", imaddr, 32'hBFC0_0000);
    check("rst_valid", pc_valid_o, 1'b0);

    step(0, 0, 1, 0, 0, 0, 0);
    check("boot_imaddr", imaddr, 32'hBFC0_0000);
    step(0, 0, 1, 0, 0, 0, 0); check("first_fetch", pc_o, 32'hBFC0_0000);
    step(0, 0, 1, 0, 0, 0, 0); check("second_fetch", pc_o, 32'hBFC0_0004);
    step(0, 0, 1, 0, 0, 0, 0); check("third_fetch", pc_o, 32'hBFC0_0008);
    step(0, 0, 1, 0, 0, 0, 0);

    repeat (3) step(0, 0, 0, 0, 0, 0, 0);
    check("notready_hold", imaddr, 32'hBFC0_0010);
    step(0, 0, 1, 0, 0, 0, 0); check("after_ready", pc_o, 32'hBFC0_0010);
    repeat (3) step(0, 0, 1, 0, 0, 0, 0);

    step(0, 1, 1, 1, 32'h8000_0100, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    check("stall_hold", imaddr, 32'hBFC0_0020);
    step(0, 0, 1, 0, 0, 0, 0);
    check("pend_issue_old", pc_o, 32'hBFC0_0020);
    check("pend_target", imaddr, 32'h8000_0100);

    step(0, 0, 1, 1, 32'h8000_0200, 1, 32'hBFC0_0380);
    check("exc_wins", imaddr, 32'hBFC0_0380);
    check("exc_flush", pc_valid_o, 1'b0);
    step(0, 0, 1, 0, 0, 0, 0);
    check("br_discarded", imaddr, 32'hBFC0_0384);

    step(0, 0, 1, 1, 32'h8000_0102, 0, 0);
    check("mis_adel", adel_o, 1'b1);
    check("mis_pc", pc_o, 32'h8000_0102);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 1, 32'hBFC0_0380);
    check("err_exit_adel", adel_o, 1'b0);
    step(0, 0, 1, 0, 0, 0, 0);
    check("err_exit_fetch", pc_o, 32'hBFC0_0380);

    for (int i = 0; i < 1500; i++) begin
      bt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) bt[1:0] = 2'($urandom_range(1, 3));
      et = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 5) == 0) et[1:0] = 2'($urandom_range(1, 3));
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, bt,
           $urandom_range(0, 14) == 0, et);
    end

    // 16-bit instance: wrap-around and reset discarding a pending branch.
    @(posedge cpu_clk_50M); #1;
    @(posedge cpu_clk_50M); #1;
    check("w16_rst_imaddr", imaddr16, 16'hFFF8);
    check("w16_rst_imce", imce16, 1'b0);
    rst16 = 1'b0; rdy16 = 1'b1;
    @(posedge cpu_clk_50M); #1;
    @(posedge cpu_clk_50M); #1; check("w16_f0", pc16, 16'hFFF8);
    @(posedge cpu_clk_50M); #1; check("w16_f1", pc16, 16'hFFFC);
    @(posedge cpu_clk_50M); #1; check("w16_wrap", pc16, 16'h0000);
    check("w16_noflag", adel16, 1'b0);
    stl16 = 1'b1; br16 = 1'b1; bt16 = 16'h1234;
    @(posedge cpu_clk_50M); #1;
    br16 = 1'b0;
    @(posedge cpu_clk_50M); #1;
    rst16 = 1'b1; stl16 = 1'b0;
    @(posedge cpu_clk_50M); #1;
    check("w16_mid_rst", imaddr16, 16'hFFF8);
    check("w16_mid_rst_valid", pcv16, 1'b0);
    rst16 = 1'b0;
    @(posedge cpu_clk_50M); #1;
    @(posedge cpu_clk_50M); #1; check("w16_reboot", pc16, 16'hFFF8);
    @(posedge cpu_clk_50M); #1; check("w16_pend_cleared", pc16, 16'hFFFC);
    check("w16_pend_cleared_addr", imaddr16, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
